// File: rtl/fetch_unit.sv
// CHIP-8 instruction fetch stage: reads the bytes at pc and pc+1 through a
// req/ack memory port and returns the big-endian 16-bit opcode.
module fetch_unit #(
    parameter int ADDR_WIDTH  = 12,
    parameter int ACK_TIMEOUT = 16,
    parameter bit WRAP        = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_fetch_req,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_busy,
    output logic [15:0]           o_opcode,
    output logic                  o_opcode_valid,
    output logic                  o_fault,
    output logic                  o_mem_read,
    output logic [ADDR_WIDTH-1:0] o_mem_read_addr,
    input  logic [7:0]            i_mem_read_data,
    input  logic                  i_mem_read_ack
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RD_HI, GAP, RD_LO} state_t;

    state_t                r_state,    w_state_nx;
    logic [ADDR_WIDTH-1:0] r_addr,     w_addr_nx;
    logic [ADDR_WIDTH-1:0] r_rd_addr,  w_rd_addr_nx;
    logic [7:0]            r_hi,       w_hi_nx;
    logic [15:0]           r_opcode,   w_opcode_nx;
    logic                  r_valid,    w_valid_nx;
    logic                  r_fault,    w_fault_nx;
    logic                  r_read,     w_read_nx;
    logic [CNT_W-1:0]      r_cnt,      w_cnt_nx;
    logic                  w_timeout;
    logic                  w_top;

    assign w_timeout = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign w_top     = &r_addr;

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        w_state_nx   = r_state;
        w_addr_nx    = r_addr;
        w_rd_addr_nx = r_rd_addr;
        w_hi_nx      = r_hi;
        w_opcode_nx  = r_opcode;
        w_valid_nx   = 1'b0;
        w_fault_nx   = 1'b0;
        w_read_nx    = r_read;
        w_cnt_nx     = r_cnt + CNT_W'(1);

        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (i_fetch_req) begin
                    w_addr_nx    = i_pc;
                    w_rd_addr_nx = i_pc;
                    w_read_nx    = 1'b1;
                    w_state_nx   = RD_HI;
                end
            end
            RD_HI: begin
                if (i_mem_read_ack) begin
                    w_hi_nx    = i_mem_read_data;
                    w_read_nx  = 1'b0;
                    w_cnt_nx   = '0;
                    w_state_nx = GAP;
                end else if (w_timeout) begin
                    w_fault_nx = 1'b1;
                    w_read_nx  = 1'b0;
                    w_state_nx = IDLE;
                end
            end
            GAP: begin
                // Wait for the high-byte ack to fall so it is not mistaken for the low-byte ack.
                if (!i_mem_read_ack) begin
                    w_cnt_nx = '0;
                    if (w_top && !WRAP) begin
                        w_fault_nx = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_read_nx    = 1'b1;
                        w_rd_addr_nx = r_addr + ADDR_WIDTH'(1);
                        w_state_nx   = RD_LO;
                    end
                end else if (w_timeout) begin
                    w_fault_nx = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            RD_LO: begin
                if (i_mem_read_ack) begin
                    w_opcode_nx = {r_hi, i_mem_read_data};
                    w_valid_nx  = 1'b1;
                    w_read_nx   = 1'b0;
                    w_state_nx  = IDLE;
                end else if (w_timeout) begin
                    w_fault_nx = 1'b1;
                    w_read_nx  = 1'b0;
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_read_nx  = 1'b0;
                w_state_nx = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rd_addr <= '0;
            r_hi      <= '0;
            r_opcode  <= '0;
            r_valid   <= 1'b0;
            r_fault   <= 1'b0;
            r_read    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_addr    <= w_addr_nx;
            r_rd_addr <= w_rd_addr_nx;
            r_hi      <= w_hi_nx;
            r_opcode  <= w_opcode_nx;
            r_valid   <= w_valid_nx;
            r_fault   <= w_fault_nx;
            r_read    <= w_read_nx;
            r_cnt     <= w_cnt_nx;
        end
    end

    assign o_busy          = (r_state != IDLE);
    assign o_opcode        = r_opcode;
    assign o_opcode_valid  = r_valid;
    assign o_fault         = r_fault;
    assign o_mem_read      = r_read;
    assign o_mem_read_addr = r_rd_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (WRAP=0 / WRAP=1) share stimulus,
// each with its own memory model holding mem[i] = i % 255.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [11:0] pc;

    logic        b0, b1, v0, v1, f0, f1, rd0, rd1;
    logic [15:0] op0, op1;
    logic [11:0] ad0, ad1;
    logic        mem_ack [2];
    logic [7:0]  mem_data [2];
    int          dly [2];

    logic [7:0]  mem [4096];
    int          ack_delay = 1;
    bit          ack_dead  = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [11:0] log0 [$];
    logic [11:0] log1 [$];
    logic        prev0 = 1'b0, prev1 = 1'b0;
    logic [11:0] pad0 = '0;
    int          unstable = 0;
    int          overlap  = 0;

    int          vk [2], fk [2], vn [2], fn [2];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_WIDTH(12), .ACK_TIMEOUT(16), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_fetch_req(fetch_req), .i_pc(pc),
        .o_busy(b0), .o_opcode(op0), .o_opcode_valid(v0), .o_fault(f0),
        .o_mem_read(rd0), .o_mem_read_addr(ad0),
        .i_mem_read_data(mem_data[0]), .i_mem_read_ack(mem_ack[0])
    );

    fetch_unit #(.ADDR_WIDTH(12), .ACK_TIMEOUT(16), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_fetch_req(fetch_req), .i_pc(pc),
        .o_busy(b1), .o_opcode(op1), .o_opcode_valid(v1), .o_fault(f1),
        .o_mem_read(rd1), .o_mem_read_addr(ad1),
        .i_mem_read_data(mem_data[1]), .i_mem_read_ack(mem_ack[1])
    );

    // Memory model: ack rises ack_delay edges after read is seen, holds while read stays high.
    always @(posedge clk) begin : mem_model
        logic        r;
        logic [11:0] a;
        for (int g = 0; g < 2; g++) begin
            r = (g == 0) ? rd0 : rd1;
            a = (g == 0) ? ad0 : ad1;
            if (!r || ack_dead) begin
                mem_ack[g] <= 1'b0;
                dly[g]     <= 0;
            end else if (!mem_ack[g]) begin
                if (dly[g] >= ack_delay - 1) begin
                    mem_ack[g]  <= 1'b1;
                    mem_data[g] <= mem[a];
                end else begin
                    dly[g] <= dly[g] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rd0 && !prev0) log0.push_back(ad0);
        if (rd1 && !prev1) log1.push_back(ad1);
        if (prev0 && rd0 && (ad0 != pad0)) unstable++;
        if ((v0 && f0) || (v1 && f1)) overlap++;
        prev0 <= rd0;
        prev1 <= rd1;
        pad0  <= ad0;
    end

    function automatic logic [7:0] mv(input int a);
        return 8'((a % 4096) % 255);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse fetch_req for one edge, then watch both instances until they return to IDLE.
    task automatic run_fetch(input logic [11:0] a, input int budget);
        int k;
        bit done;
        log0.delete();
        log1.delete();
        vk = '{0, 0}; fk = '{0, 0}; vn = '{0, 0}; fn = '{0, 0};
        pc        = a;
        fetch_req = 1'b1;
        k         = 0;
        done      = 1'b0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
            fetch_req = 1'b0;
            if (v0) begin vn[0]++; if (vk[0] == 0) vk[0] = k; end
            if (v1) begin vn[1]++; if (vk[1] == 0) vk[1] = k; end
            if (f0) begin fn[0]++; if (fk[0] == 0) fk[0] = k; end
            if (f1) begin fn[1]++; if (fk[1] == 0) fk[1] = k; end
            if (!b0 && !b1) done = 1'b1;
        end
        check("fetch_done", 32'(done), 32'd1);
    endtask

    initial begin
        int n, k, last;
        for (int i = 0; i < 4096; i++) mem[i] = mv(i);
        rst_n     = 1'b0;
        fetch_req = 1'b0;
        pc        = '0;
        repeat (3) @(negedge clk);

        check("rst_busy",   32'(b0),  32'd0);
        check("rst_read",   32'(rd0), 32'd0);
        check("rst_addr",   32'(ad0), 32'd0);
        check("rst_opcode", 32'(op0), 32'd0);
        check("rst_valid",  32'(v0),  32'd0);
        check("rst_fault",  32'(f0),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic fetch at 0x200, 1-cycle memory.
        run_fetch(12'h200, 30);
        check("t2_latency", 32'(vk[0]), 32'd7);
        check("t2_vcount",  32'(vn[0]), 32'd1);
        check("t2_fcount",  32'(fn[0]), 32'd0);
        check("t2_opcode",  32'(op0),   32'({mv(12'h200), mv(12'h201)}));
        check("t2_nreads",  32'(log0.size()), 32'd2);
        check("t2_rd0",     32'(log0[0]), 32'h200);
        check("t2_rd1",     32'(log0[1]), 32'h201);
        check("t2_busy",    32'(b0), 32'd0);

        // Straddle at the top address: fault without WRAP, wrap to 0x000 with it.
        run_fetch(12'hFFF, 30);
        check("t3_nreads",  32'(log0.size()), 32'd1);
        check("t3_rd0",     32'(log0[0]), 32'hFFF);
        check("t3_fault",   32'(fn[0]), 32'd1);
        check("t3_novalid", 32'(vn[0]), 32'd0);
        check("t3_keep_op", 32'(op0), 32'({mv(12'h200), mv(12'h201)}));
        check("t3w_nreads", 32'(log1.size()), 32'd2);
        check("t3w_rd1",    32'(log1[1]), 32'h000);
        check("t3w_valid",  32'(vn[1]), 32'd1);
        check("t3w_fault",  32'(fn[1]), 32'd0);
        check("t3w_opcode", 32'(op1), 32'({mv(12'hFFF), mv(0)}));

        // Asynchronous reset while waiting in RD_HI.
        ack_delay = 3;
        pc        = 12'h300;
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        check("t1_pre_read", 32'(rd0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t1_read",   32'(rd0), 32'd0);
        check("t1_busy",   32'(b0),  32'd0);
        check("t1_valid",  32'(v0),  32'd0);
        check("t1_fault",  32'(f0),  32'd0);
        check("t1_opcode", 32'(op0), 32'd0);
        check("t1w_opcode", 32'(op1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Memory that never acknowledges.
        ack_dead  = 1'b1;
        ack_delay = 1;
        run_fetch(12'h050, 40);
        check("t4_fault_at", 32'(fk[0]), 32'd17);
        check("t4_fcount",   32'(fn[0]), 32'd1);
        check("t4_novalid",  32'(vn[0]), 32'd0);
        check("t4_read",     32'(rd0), 32'd0);
        check("t4_nreads",   32'(log0.size()), 32'd1);
        ack_dead = 1'b0;
        @(negedge clk);

        // Slow memory: ack after 3 cycles.
        ack_delay = 3;
        unstable  = 0;
        run_fetch(12'h123, 60);
        check("t6_stable",  32'(unstable), 32'd0);
        check("t6_fcount",  32'(fn[0]), 32'd0);
        check("t6_vcount",  32'(vn[0]), 32'd1);
        check("t6_latency", 32'(vk[0]), 32'd11);
        check("t6_opcode",  32'(op0), 32'({mv(12'h123), mv(12'h124)}));

        // Back-to-back fetches with fetch_req held high.
        ack_delay = 1;
        log0.delete();
        @(negedge clk);
        pc        = '0;
        fetch_req = 1'b1;
        n         = 0;
        k         = 0;
        last      = 0;
        while (n < 128 && k < 1200) begin
            @(negedge clk);
            k++;
            if (v0) begin
                check("t5_opcode", 32'(op0), 32'({mv(2 * n), mv(2 * n + 1)}));
                n++;
                pc   = 12'(2 * n);
                last = k;
                if (n == 128) fetch_req = 1'b0;
            end
        end
        check("t5_count",  32'(n), 32'd128);
        check("t5_cycles", 32'(last), 32'd896);
        repeat (3) @(negedge clk);
        check("t5_nreads", 32'(log0.size()), 32'd256);
        check("t5_idle",   32'(b0), 32'd0);
        check("no_overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
